mvu_mem_bank_ctrl: RTL and testbench
====================================

MVU_MEM_BANK_CTRL -- requirements
Module: mvu_mem_bank_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h7000_0000, start of the 32 MB MVU memory window.
REQ-002 SHALL have parameter RAM_AW, default 12, word-address width of each bank RAM.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..4, bank RAM read latency in cycles.
REQ-004 SHALL have parameter INIT_EN, default 1, enabling zero-fill of all banks after reset.
REQ-005 SHALL have port clk_i, in, 1: the only clock.
REQ-006 SHALL have port rst_ni, in, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port mem_req_i, in, 1: request from the upstream AXI-to-memory converter.
REQ-008 SHALL have port mem_gnt_o, out, 1: request accepted this cycle.
REQ-009 SHALL have ports mem_we_i (in, 1), mem_addr_i (in, 32, byte address), mem_strb_i (in, 4) and mem_wdata_i (in, 32).
REQ-010 SHALL have ports mem_rdata_o (out, 32) and mem_rvalid_o (out, 1): response for every granted request, read or write.
REQ-011 SHALL have ports ram_req_o, ram_we_o (out, [4]), ram_addr_o (out, [4][RAM_AW]), ram_be_o (out, [4][4]) and ram_wdata_o (out, 32, shared); index = bank (0 WRAM, 1 DRAM, 2 SRAM, 3 BRAM).
REQ-012 SHALL have port ram_rdata_i, in, [4][32].
REQ-013 SHALL have ports init_done_o (out, 1), err_o (out, 1, sticky decode error) and err_cnt_o (out, 16).

Function
REQ-014 SHALL use a two-state FSM: INIT, READY; reset enters INIT if INIT_EN=1, else READY.
REQ-015 In INIT, SHALL write 32'h0 with be 4'hF to word counter 0..2^RAM_AW-1 on all four banks in the same cycle, one word per cycle, with mem_gnt_o=0.
REQ-016 SHALL move INIT->READY in the cycle after the write of word 2^RAM_AW-1, and drive init_done_o=1 while in READY.
REQ-017 In READY, mem_gnt_o SHALL equal mem_req_i (no backpressure).
REQ-018 Decode: off = mem_addr_i - BASE_ADDR; bank = off[24:23]; word = off[RAM_AW+1:2].
REQ-019 A request with off >= 32'h0200_0000, or with any of off[22:RAM_AW+2] nonzero, SHALL be a decode error.
REQ-020 A decode-error request SHALL assert no ram_req_o bit, set err_o, and increment err_cnt_o, saturating at 16'hFFFF.
REQ-021 A valid granted request SHALL assert exactly ram_req_o[bank] in the same cycle, with ram_we_o[bank]=mem_we_i, ram_be_o[bank]=mem_strb_i, ram_addr_o[bank]=word and ram_wdata_o=mem_wdata_i.
REQ-022 mem_rvalid_o SHALL pulse exactly RD_LAT cycles after each grant; responses SHALL stay in order and back-to-back grants SHALL give back-to-back rvalids.
REQ-023 mem_rdata_o SHALL be ram_rdata_i[bank] for a valid read, and 32'h0 for a write or a decode error.
REQ-024 The in-flight bank, we and error tags SHALL travel through an RD_LAT-deep pipeline alongside the valid bit.
REQ-025 When not requesting, ram_* outputs SHALL be 0 (ram_wdata_o may hold its last value).

Reset
REQ-026 On rst_ni low, SHALL immediately clear: FSM, init counter, response pipeline, mem_rvalid_o, mem_gnt_o, err_o, err_cnt_o and init_done_o.
REQ-027 Reset asserted mid-INIT or with reads in flight SHALL drop all pending responses; INIT restarts from word 0.
REQ-028 All outputs SHALL be 0 while rst_ni is low.

Structure
REQ-029 The bank enum (WRAM/DRAM/SRAM/BRAM), BANK_SZ=32'h0080_0000 and the window size 32'h0200_0000 SHALL live in mvu_pkg.
REQ-030 The latency pipeline SHALL be a separate sub-module, mvu_mem_rsp_pipe, parameterised by depth and tag type.

Verification
REQ-031 Reset release with RAM_AW=4 and INIT_EN=1 -> 16 zero-write cycles on all banks, gnt low throughout, init_done_o=1 on cycle 17.
REQ-032 Write 32'hCAFEBABE strb 4'hF to 32'h7080_0010, then read it back (RD_LAT=2) -> ram_req_o=4'b0010 at addr 4; the read gives rvalid 2 cycles after grant with rdata CAFEBABE.
REQ-033 Back-to-back reads to banks 0,3,1,2 with RD_LAT=3 -> four consecutive rvalids, in order, each carrying that bank's rdata.
REQ-034 Read 32'h7200_0000 and read 32'h7000_4000 (RAM_AW=12) -> no ram_req, rvalid with 0, err_o=1 and err_cnt_o=2.
REQ-035 Preload err_cnt_o to 16'hFFFF, then issue an error request -> err_cnt_o stays FFFF.
REQ-036 Assert rst_ni low with 2 reads in flight -> no rvalid after reset, INIT restarts at word 0.

Source files
------------

// File: rtl/mvu_pkg.sv
// ---------------------------------------------------------------------------
// mvu_pkg
// Shared types and constants for the MVU memory bank controller.
//   bank_e            : bank index (WRAM/DRAM/SRAM/BRAM) carried on ram_* arrays
//   ctrl_state_e      : controller FSM state, also exported on the debug port
//   rsp_tag_t         : per-request tag that rides the response pipeline
//   BANK_SZ / WIN_SZ  : size of one bank slot and of the whole 32 MB window
//   unused_bits_mask  : in-bank offset bits that lie above a RAM's word range
// ---------------------------------------------------------------------------
package mvu_pkg;

  localparam logic [31:0] BANK_SZ = 32'h0080_0000;
  localparam logic [31:0] WIN_SZ  = 32'h0200_0000;

  typedef enum logic [1:0] {
    BANK_WRAM = 2'd0,
    BANK_DRAM = 2'd1,
    BANK_SRAM = 2'd2,
    BANK_BRAM = 2'd3
  } bank_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    bank_e bank;
    logic  we;
    logic  err;
  } rsp_tag_t;

  // Bits [22:ram_aw+2] of the offset: a bank slot is 8 MB but the RAM behind
  // it only covers 2^ram_aw words, so any of these bits set is unmapped.
  function automatic logic [31:0] unused_bits_mask(input int unsigned ram_aw);
    return (BANK_SZ - 32'd1) & ~((32'd1 << (ram_aw + 32'd2)) - 32'd1);
  endfunction

endpackage

// File: rtl/mvu_mem_rsp_pipe.sv
// ---------------------------------------------------------------------------
// mvu_mem_rsp_pipe
// Fixed-latency shift pipeline that carries a valid bit and a tag of any
// packed type, so the response leaves exactly DEPTH cycles after entry.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all stages)
//   i_valid/i_tag : entry side, sampled every cycle
//   o_valid/o_tag : exit side, DEPTH cycles later
// ---------------------------------------------------------------------------
module mvu_mem_rsp_pipe #(
  parameter int  DEPTH = 1,
  parameter type tag_t = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_valid,
  input  tag_t i_tag,
  output logic o_valid,
  output tag_t o_tag
);

  logic r_valid [DEPTH];
  tag_t r_tag   [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/mvu_mem_bank_ctrl.sv
// ---------------------------------------------------------------------------
// mvu_mem_bank_ctrl
// Decodes a 32 MB memory window into four bank RAMs (WRAM, DRAM, SRAM, BRAM),
// zero-fills all banks after reset, and returns one in-order response per
// granted request after a fixed RD_LAT cycles.
//
// Ports
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   mem_req_i / mem_gnt_o    : upstream request / accept
//   mem_we_i, mem_addr_i,
//   mem_strb_i, mem_wdata_i  : request payload (byte address)
//   mem_rdata_o, mem_rvalid_o: response, one per grant, RD_LAT cycles later
//   ram_req_o .. ram_wdata_o : per-bank RAM command (wdata shared)
//   ram_rdata_i              : per-bank RAM read data, RD_LAT after command
//   init_done_o              : high once zero-fill has finished
//   err_o, err_cnt_o         : sticky decode error, saturating error count
//   dbg_state_o              : current FSM state
//
// Handshake: a request transfers in any cycle where mem_req_i and mem_gnt_o
// are both high. During zero-fill mem_gnt_o is held low; afterwards it simply
// follows mem_req_i (no backpressure). Every transfer, read, write or decode
// error, produces exactly one mem_rvalid_o pulse RD_LAT cycles later, in order.
// ---------------------------------------------------------------------------
module mvu_mem_bank_ctrl
  import mvu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
  parameter int          RAM_AW    = 12,
  parameter int          RD_LAT    = 1,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic                   mem_we_i,
  input  logic [31:0]            mem_addr_i,
  input  logic [3:0]             mem_strb_i,
  input  logic [31:0]            mem_wdata_i,
  output logic [31:0]            mem_rdata_o,
  output logic                   mem_rvalid_o,
  output logic [3:0]             ram_req_o,
  output logic [3:0]             ram_we_o,
  output logic [3:0][RAM_AW-1:0] ram_addr_o,
  output logic [3:0][3:0]        ram_be_o,
  output logic [31:0]            ram_wdata_o,
  input  logic [3:0][31:0]       ram_rdata_i,
  output logic                   init_done_o,
  output logic                   err_o,
  output logic [15:0]            err_cnt_o,
  output ctrl_state_e            dbg_state_o
);

  localparam logic [31:0]       HI_MASK   = unused_bits_mask(RAM_AW);
  localparam logic [RAM_AW-1:0] LAST_WORD = '1;

  ctrl_state_e       r_state;
  logic [RAM_AW-1:0] r_init_cnt;
  logic              r_err;
  logic [15:0]       r_err_cnt;

  logic [31:0]       w_off;
  logic [1:0]        w_bank;
  logic [RAM_AW-1:0] w_word;
  logic              w_dec_err;
  logic              w_init_wr;
  logic              w_gnt;
  rsp_tag_t          w_req_tag;
  rsp_tag_t          w_rsp_tag;
  logic              w_rsp_valid;

  // Address decode. Addresses below BASE_ADDR wrap to a huge offset and so
  // fall into the out-of-window error case.
  assign w_off     = mem_addr_i - BASE_ADDR;
  assign w_bank    = w_off[24:23];
  assign w_word    = w_off[RAM_AW+1:2];
  assign w_dec_err = (w_off >= WIN_SZ) || ((w_off & HI_MASK) != 32'd0);

  // Qualified with rst_ni so every port reads zero during reset, including
  // the INIT_EN=0 case where the reset state is already READY.
  assign w_init_wr = rst_ni && (r_state == ST_INIT);
  assign w_gnt     = rst_ni && (r_state == ST_READY) && mem_req_i;

  // RAM command: zero-fill of all banks during INIT, otherwise one bank for a
  // valid granted request, otherwise idle.
  always_comb begin
    ram_req_o   = '0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (w_init_wr) begin
      ram_req_o  = 4'hF;
      ram_we_o   = 4'hF;
      ram_be_o   = '1;
      ram_addr_o = {4{r_init_cnt}};
    end else if (w_gnt && !w_dec_err) begin
      ram_req_o[w_bank]  = 1'b1;
      ram_we_o[w_bank]   = mem_we_i;
      ram_be_o[w_bank]   = mem_strb_i;
      ram_addr_o[w_bank] = w_word;
      ram_wdata_o        = mem_wdata_i;
    end
  end

  // Controller FSM plus error bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= INIT_EN ? ST_INIT : ST_READY;
      r_init_cnt <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Counter wraps back to zero on the last word, leaving it ready
          // for the next zero-fill.
          r_init_cnt <= r_init_cnt + RAM_AW'(1);
          if (r_init_cnt == LAST_WORD) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_gnt && w_dec_err) begin
            r_err <= 1'b1;
            if (r_err_cnt != 16'hFFFF) begin
              r_err_cnt <= r_err_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Response path: the tag tells the exit stage which bank to return and
  // whether the response must be forced to zero (write or decode error).
  assign w_req_tag = '{bank: bank_e'(w_bank), we: mem_we_i, err: w_dec_err};

  mvu_mem_rsp_pipe #(
    .DEPTH (RD_LAT),
    .tag_t (rsp_tag_t)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_valid (w_gnt),
    .i_tag   (w_req_tag),
    .o_valid (w_rsp_valid),
    .o_tag   (w_rsp_tag)
  );

  assign mem_rvalid_o = w_rsp_valid;
  assign mem_rdata_o  = (w_rsp_valid && !w_rsp_tag.we && !w_rsp_tag.err)
                        ? ram_rdata_i[w_rsp_tag.bank] : 32'h0;

  assign mem_gnt_o   = w_gnt;
  assign init_done_o = rst_ni && (r_state == ST_READY);
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mvu_mem_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mvu_mem_bank_ctrl
// Two controllers (RD_LAT=2 and RD_LAT=3, RAM_AW=4) share one request stream.
// Each has its own behavioural bank RAM. A reference model built from the
// address-map arithmetic predicts every RAM command, grant and response.
// ---------------------------------------------------------------------------
module tb_mvu_mem_bank_ctrl;
  import mvu_pkg::*;

  localparam int          AW   = 4;
  localparam int          NW   = 1 << AW;
  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam logic [31:0] BANK = 32'h0080_0000;
  localparam logic [31:0] WIN  = 32'h0200_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;

  logic                gnt       [2];
  logic [31:0]         rdata     [2];
  logic                rvalid    [2];
  logic [3:0]          ram_req   [2];
  logic [3:0]          ram_we    [2];
  logic [3:0][AW-1:0]  ram_addr  [2];
  logic [3:0][3:0]     ram_be    [2];
  logic [31:0]         ram_wdata [2];
  logic [3:0][31:0]    ram_rdata [2];
  logic                init_done [2];
  logic                err       [2];
  logic [15:0]         err_cnt   [2];
  ctrl_state_e         dbg_state [2];

  mvu_mem_bank_ctrl #(.BASE_ADDR(BASE), .RAM_AW(AW), .RD_LAT(2), .INIT_EN(1'b1)) u_dut_l2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_gnt_o(gnt[0]),
    .mem_we_i(we), .mem_addr_i(addr), .mem_strb_i(strb), .mem_wdata_i(wdata),
    .mem_rdata_o(rdata[0]), .mem_rvalid_o(rvalid[0]),
    .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]),
    .ram_be_o(ram_be[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]),
    .init_done_o(init_done[0]), .err_o(err[0]), .err_cnt_o(err_cnt[0]),
    .dbg_state_o(dbg_state[0])
  );

  mvu_mem_bank_ctrl #(.BASE_ADDR(BASE), .RAM_AW(AW), .RD_LAT(3), .INIT_EN(1'b1)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_gnt_o(gnt[1]),
    .mem_we_i(we), .mem_addr_i(addr), .mem_strb_i(strb), .mem_wdata_i(wdata),
    .mem_rdata_o(rdata[1]), .mem_rvalid_o(rvalid[1]),
    .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]),
    .ram_be_o(ram_be[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]),
    .init_done_o(init_done[1]), .err_o(err[1]), .err_cnt_o(err_cnt[1]),
    .dbg_state_o(dbg_state[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic string tg(input string s, input int k);
    return $sformatf("%s_L%0d", s, lat_of(k));
  endfunction

  // ---------------- scoreboard / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural bank RAMs ----------------
  // Commands are captured at negedge and applied at the next posedge; read
  // data appears RD_LAT cycles after the command cycle. Idle stages carry a
  // marker so a response taken at the wrong time shows up as bad data.
  logic [31:0]        ram_mem [2][4][NW];
  logic [31:0]        rd_pipe [2][4][4];
  logic [3:0]         c_req   [2];
  logic [3:0]         c_we    [2];
  logic [3:0][AW-1:0] c_addr  [2];
  logic [3:0][3:0]    c_be    [2];
  logic [31:0]        c_wdata [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      c_req[k] = '0; c_we[k] = '0; c_addr[k] = '0; c_be[k] = '0; c_wdata[k] = '0;
      for (int b = 0; b < 4; b++) begin
        for (int s = 0; s < 4; s++) rd_pipe[k][b][s] = '0;
        for (int w = 0; w < NW; w++) ram_mem[k][b][w] = $urandom;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++) begin
        for (int s = 3; s > 0; s--) rd_pipe[k][b][s] = rd_pipe[k][b][s-1];
        rd_pipe[k][b][0] = 32'hDEAD_0000 | 32'(b);
        if (c_req[k][b]) begin
          if (c_we[k][b]) begin
            for (int i = 0; i < 4; i++)
              if (c_be[k][b][i]) ram_mem[k][b][c_addr[k][b]][8*i +: 8] = c_wdata[k][8*i +: 8];
          end else begin
            rd_pipe[k][b][0] = ram_mem[k][b][c_addr[k][b]];
          end
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++)
        ram_rdata[k][b] = rd_pipe[k][b][lat_of(k)-1];
  end

  // ---------------- reference model ----------------
  int          n = 0;           // cycles since reset release
  logic [31:0] ref_mem [4][NW];
  logic        m_err;
  int          m_err_cnt;
  logic [63:0] exp_q2[$];       // {due cycle, rdata} for RD_LAT=2
  logic [63:0] exp_q3[$];       // {due cycle, rdata} for RD_LAT=3

  always @(posedge clk) n <= rst_n ? n + 1 : 0;

  always @(negedge clk) begin
    logic [31:0]        off, e_rd, e_wd, e_rdata;
    int                 bk, wd;
    logic               dec_err, ready, e_rv;
    logic [3:0]         e_req, e_we;
    logic [3:0][AW-1:0] e_addr;
    logic [3:0][3:0]    e_be;
    logic [63:0]        ent;

    for (int k = 0; k < 2; k++) begin
      c_req[k] = ram_req[k]; c_we[k] = ram_we[k]; c_addr[k] = ram_addr[k];
      c_be[k] = ram_be[k]; c_wdata[k] = ram_wdata[k];
    end

    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check(tg("rst_gnt", k),     64'(gnt[k]),       64'(0));
        check(tg("rst_rvalid", k),  64'(rvalid[k]),    64'(0));
        check(tg("rst_ram_req", k), 64'(ram_req[k]),   64'(0));
        check(tg("rst_done", k),    64'(init_done[k]), 64'(0));
        check(tg("rst_err", k),     64'(err[k]),       64'(0));
        check(tg("rst_errcnt", k),  64'(err_cnt[k]),   64'(0));
      end
      exp_q2.delete();
      exp_q3.delete();
      m_err = 1'b0;
      m_err_cnt = 0;
      for (int b = 0; b < 4; b++)
        for (int w = 0; w < NW; w++) ref_mem[b][w] = '0;
    end else begin
      ready   = (n >= NW);
      off     = addr - BASE;
      dec_err = (off >= WIN) || ((off % BANK) >= 32'(NW * 4));
      bk      = int'(off / BANK);
      wd      = int'((off % BANK) / 32'd4);

      e_req = '0; e_we = '0; e_addr = '0; e_be = '0; e_wd = '0;
      if (!ready) begin
        e_req = 4'hF; e_we = 4'hF; e_be = '1;
        for (int b = 0; b < 4; b++) e_addr[b] = n[AW-1:0];
      end else if (req && !dec_err) begin
        e_req[bk] = 1'b1; e_we[bk] = we; e_be[bk] = strb;
        e_addr[bk] = wd[AW-1:0]; e_wd = wdata;
      end

      for (int k = 0; k < 2; k++) begin
        e_rv = 1'b0;
        e_rdata = '0;
        if (k == 0) begin
          if (exp_q2.size() != 0 && exp_q2[0][63:32] == 32'(n)) begin
            ent = exp_q2.pop_front(); e_rv = 1'b1; e_rdata = ent[31:0];
          end
        end else begin
          if (exp_q3.size() != 0 && exp_q3[0][63:32] == 32'(n)) begin
            ent = exp_q3.pop_front(); e_rv = 1'b1; e_rdata = ent[31:0];
          end
        end
        check(tg("rvalid", k), 64'(rvalid[k]), 64'(e_rv));
        if (e_rv) check(tg("rdata", k), 64'(rdata[k]), 64'(e_rdata));
        check(tg("gnt", k),      64'(gnt[k]),       64'(ready && req));
        check(tg("done", k),     64'(init_done[k]), 64'(ready));
        check(tg("ram_req", k),  64'(ram_req[k]),   64'(e_req));
        check(tg("ram_we", k),   64'(ram_we[k]),    64'(e_we));
        check(tg("ram_addr", k), 64'(ram_addr[k]),  64'(e_addr));
        check(tg("ram_be", k),   64'(ram_be[k]),    64'(e_be));
        if (e_req != 4'h0) check(tg("ram_wdata", k), 64'(ram_wdata[k]), 64'(e_wd));
        check(tg("err", k),      64'(err[k]),       64'(m_err));
        check(tg("err_cnt", k),  64'(err_cnt[k]),   64'(m_err_cnt));
      end

      // This cycle's transfer takes effect at the coming clock edge.
      if (ready && req) begin
        e_rd = '0;
        if (!we && !dec_err) e_rd = ref_mem[bk][wd];
        exp_q2.push_back({32'(n + 2), e_rd});
        exp_q3.push_back({32'(n + 3), e_rd});
        if (dec_err) begin
          m_err = 1'b1;
          if (m_err_cnt < 65535) m_err_cnt++;
        end else if (we) begin
          for (int i = 0; i < 4; i++)
            if (strb[i]) ref_mem[bk][wd][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req = r; we = w; addr = a; strb = s; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    req = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_req();
    logic [31:0] a, b, w;
    b = $urandom_range(0, 3);
    w = $urandom_range(0, NW - 1);
    case ($urandom_range(0, 9))
      0:       a = BASE + WIN + $urandom_range(0, 4095);
      1:       a = BASE + b * BANK + 32'(NW * 4) + 32'd4 * $urandom_range(0, 1000);
      2:       a = BASE - 32'd4 * $urandom_range(1, 16);
      default: a = BASE + b * BANK + w * 32'd4 + $urandom_range(0, 3);
    endcase
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
          4'($urandom_range(0, 15)), $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; strb = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-fill: requests offered now must not be granted.
    for (int i = 0; i < NW; i++)
      drive(1'($urandom_range(0, 1)), 1'b0, BASE + 32'(4 * i), 4'hF, $urandom);
    req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(tg("init_done_first_ready", k), 64'(init_done[k]), 64'(1));
      check(tg("state_ready", k),           64'(dbg_state[k]), 64'(ST_READY));
    end
    @(posedge clk);
    #1;

    // Write then read back through DRAM word 4.
    drive(1'b1, 1'b1, 32'h7080_0010, 4'hF, 32'hCAFE_BABE);
    drive(1'b1, 1'b0, 32'h7080_0010, 4'h0, 32'h0);
    idle(5);

    // Distinct data in each bank, then back-to-back reads 0,3,1,2.
    for (int b = 0; b < 4; b++)
      drive(1'b1, 1'b1, BASE + 32'(b) * BANK + 32'h14, 4'hF, 32'h1111_1111 * 32'(b + 1));
    drive(1'b1, 1'b0, BASE + 32'h0000_0014, 4'h0, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'h0180_0014, 4'h0, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'h0080_0014, 4'h0, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'h0100_0014, 4'h0, 32'h0);
    idle(6);

    // Two decode errors: outside the window, and above the RAM word range.
    drive(1'b1, 1'b0, 32'h7200_0000, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h7000_4000, 4'h0, 32'h0);
    idle(2);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(tg("err_after_two", k),     64'(err[k]),     64'(1));
      check(tg("err_cnt_after_two", k), 64'(err_cnt[k]), 64'(2));
    end
    @(posedge clk);
    #1;

    // Mixed random traffic.
    for (int i = 0; i < 400; i++) rand_req();
    idle(5);

    // Drive the error counter into saturation.
    for (int i = 0; i < 65540; i++) drive(1'b1, 1'b0, BASE + WIN, 4'h0, 32'h0);
    idle(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check(tg("err_cnt_saturated", k), 64'(err_cnt[k]), 64'(16'hFFFF));
    @(posedge clk);
    #1;

    // Reset with two reads in flight.
    drive(1'b1, 1'b0, BASE + BANK + 32'h8, 4'h0, 32'h0);
    drive(1'b1, 1'b0, BASE + 2 * BANK + 32'h8, 4'h0, 32'h0);
    req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(tg("restart_state", k), 64'(dbg_state[k]), 64'(ST_INIT));
      check(tg("restart_addr", k),  64'(ram_addr[k]),  64'(0));
    end
    @(posedge clk);
    #1;
    idle(NW + 8);

    check("pending_L2", 64'(exp_q2.size()), 64'(0));
    check("pending_L3", 64'(exp_q3.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
